// File: rtl/r8_booth_seq_mac_pkg.sv
// Shared constants, FSM state type and the radix-8 Booth digit encoding
// for the R8ACC sequential multiplier family.
package r8acc_pkg;

  localparam int A_W  = 16;
  localparam int B_W  = 16;
  localparam int P_W  = 32;
  localparam int NDIG = 6;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Window {b[3i+2], b[3i+1], b[3i], b[3i-1]} -> {neg, one-hot |d|}; f is never all-zero.
  function automatic logic [5:0] booth_r8_digit(input logic [3:0] w);
    logic [2:0] mag;
    case (w)
      4'b0000, 4'b1111:                   mag = 3'd0;
      4'b0001, 4'b0010, 4'b1101, 4'b1110: mag = 3'd1;
      4'b0011, 4'b0100, 4'b1011, 4'b1100: mag = 3'd2;
      4'b0101, 4'b0110, 4'b1001, 4'b1010: mag = 3'd3;
      default:                            mag = 3'd4;
    endcase
    return {w[3] && (mag != 3'd0), 5'(5'b00001 << mag)};
  endfunction

endpackage

// File: rtl/r8_booth_seq_mac_enc.sv
// Pure combinational radix-8 Booth window encoder driving choose_prod selects.
module booth_r8_enc
  import r8acc_pkg::*;
(
  input  logic [3:0] win,
  output logic       neg,
  output logic [4:0] f
);

  always_comb begin
    {neg, f} = booth_r8_digit(win);
  end

endmodule

// File: rtl/r8_booth_seq_mac.sv
// Sequential radix-8 Booth multiply controller: one digit per RUN cycle,
// partial products come back from an external choose_prod instance.
module r8_booth_seq_mac
  import r8acc_pkg::*;
#(
  parameter int A_W = r8acc_pkg::A_W,
  parameter int B_W = r8acc_pkg::B_W,
  parameter int P_W = r8acc_pkg::P_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a_in,
  input  logic [B_W-1:0] b_in,
  output logic [A_W-1:0] pp_a,
  output logic           pp_neg,
  output logic [4:0]     pp_f,
  input  logic [P_W-1:0] pp_prod,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] result,
  output logic           busy
);

  localparam int NDIG  = (B_W + 3) / 3;
  localparam int EXT_W = 3 * NDIG + 1;
  localparam int CNT_W = $clog2(NDIG);
  localparam int SH_W  = $clog2(P_W);

  state_t             state, state_next;
  logic [EXT_W-1:0]   b_ext;
  logic [CNT_W-1:0]   cnt;
  logic [P_W-1:0]     acc;
  logic [P_W-1:0]     acc_next;
  logic [SH_W-1:0]    base;
  logic [3:0]         win;
  logic               last;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);

  assign last     = (cnt == CNT_W'(NDIG - 1));
  assign base     = SH_W'(cnt) * SH_W'(3);
  assign win      = 4'(b_ext >> base);
  assign acc_next = acc + (pp_prod << base);

  booth_r8_enc u_enc (
    .win (win),
    .neg (pp_neg),
    .f   (pp_f)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last)     state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // cnt returns to 0 when leaving RUN so the encoder window stays in range.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pp_a   <= '0;
      b_ext  <= '0;
      cnt    <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pp_a  <= a_in;
            b_ext <= {{(EXT_W - B_W - 1){b_in[B_W-1]}}, b_in, 1'b0};
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= acc_next;
          if (last) begin
            result <= acc_next;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_r8_booth_seq_mac.sv
// Directed bench for r8_booth_seq_mac with an exact choose_prod stand-in.
module tb_r8_booth_seq_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [15:0] pp_a;
  logic        pp_neg;
  logic [4:0]  pp_f;
  logic [31:0] pp_prod;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  r8_booth_seq_mac #(.A_W(16), .B_W(16), .P_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .pp_a      (pp_a),
    .pp_neg    (pp_neg),
    .pp_f      (pp_f),
    .pp_prod   (pp_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  // choose_prod model: priority f0..f3, f4 as default, exact 3A multiple.
  always_comb begin
    logic signed [31:0] a_sx;
    logic signed [31:0] m;
    a_sx = 32'(signed'(pp_a));
    if (pp_f[0])      m = 32'sd0;
    else if (pp_f[1]) m = a_sx;
    else if (pp_f[2]) m = a_sx * 2;
    else if (pp_f[3]) m = a_sx * 3;
    else              m = a_sx * 4;
    pp_prod = pp_neg ? -m : m;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_in_ready", 32'(in_ready), 32'd0);
    check("accept_pp_a", 32'(pp_a), 32'(a));
  endtask

  task automatic wait_done(input int n_before, input logic [31:0] exp, input string tag);
    repeat (n_before) @(posedge clk);
    #1;
    check({tag, "_not_yet"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, result, exp);
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("take_out_valid", 32'(out_valid), 32'd0);
    check("take_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    a_in      = 16'h0005;
    b_in      = 16'h0009;
    out_ready = 1'b0;

    // Reset held with in_valid high: nothing accepted
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_pp_f", 32'(pp_f), 32'h01);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pp_a", 32'(pp_a), 32'h0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    check("idle_no_accept", 32'(busy), 32'd0);

    // 5 * 9: digits +1,+1,0,0,0,0
    start_op(16'h0005, 16'h0009);
    check("d0_neg", 32'(pp_neg), 32'd0);
    check("d0_f", 32'(pp_f), 32'h02);
    // operand offered during RUN/DONE must wait
    in_valid = 1'b1;
    a_in     = 16'h1234;
    b_in     = 16'h0001;
    @(posedge clk); #1;
    check("d1_f", 32'(pp_f), 32'h02);
    wait_done(4, 32'h0000002D, "exact45");

    // backpressure for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_result", result, 32'h0000002D);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_not_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("late_accept_busy", 32'(busy), 32'd1);
    check("late_accept_pp_a", 32'(pp_a), 32'h1234);
    wait_done(5, 32'h00001234, "times1");
    take_result();

    // -2 * -4: digit0 = -4
    start_op(16'hFFFE, 16'hFFFC);
    check("neg_d0_neg", 32'(pp_neg), 32'd1);
    check("neg_d0_f", 32'(pp_f), 32'h10);
    wait_done(5, 32'h00000008, "neg");
    take_result();

    start_op(16'h8000, 16'h8000);
    wait_done(5, 32'h40000000, "minmin");
    take_result();

    start_op(16'h7FFF, 16'h8000);
    wait_done(5, 32'hC0008000, "maxmin");
    take_result();

    // Abort in RUN at cnt==3
    start_op(16'h1111, 16'h7777);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", result, 32'h0);
    check("abort_pp_f", 32'(pp_f), 32'h01);
    check("abort_pp_a", 32'(pp_a), 32'h0);

    // 3 * 2: digit0 = +2
    start_op(16'h0003, 16'h0002);
    check("post_d0_f", 32'(pp_f), 32'h04);
    wait_done(5, 32'h00000006, "post_abort");
    take_result();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
